// File: rtl/module_control_pkg.sv
// Mini-CPU shared definitions: CPU state codes, opcodes and instruction field positions.
package module_control_pkg;

  typedef enum logic [2:0] {
    ST_OFF    = 3'b000,
    ST_FETCH  = 3'b001,
    ST_DECODE = 3'b010,
    ST_READ   = 3'b011,
    ST_CALC   = 3'b100,
    ST_SHOW   = 3'b101,
    ST_STORE  = 3'b110
  } state_t;

  typedef enum logic [2:0] {
    OP_LOAD    = 3'b000,
    OP_ADD     = 3'b001,
    OP_ADDI    = 3'b010,
    OP_SUB     = 3'b011,
    OP_SUBI    = 3'b100,
    OP_MUL     = 3'b101,
    OP_CLEAR   = 3'b110,
    OP_DISPLAY = 3'b111
  } opcode_t;

  localparam int INSTR_W   = 18;
  localparam int OP_MSB    = 17;
  localparam int OP_LSB    = 15;
  localparam int DEST_MSB  = 14;
  localparam int DEST_LSB  = 11;
  localparam int SRC1_MSB  = 10;
  localparam int SRC1_LSB  = 7;
  localparam int SRC2_MSB  = 6;
  localparam int SRC2_LSB  = 3;
  localparam int SIGN_BIT  = 6;
  localparam int IMM_MSB   = 5;
  localparam int IMM_LSB   = 0;

endpackage

// File: rtl/module_edge_detect.sv
// Rising-edge pulse for a debounced button; history starts at 1 so a button held through reset is not seen.
module module_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (!rst_n) prev <= 1'b1;
    else        prev <= btn;
  end

  assign pulse = btn & ~prev;

endmodule

// File: rtl/module_control.sv
// Mini-CPU sequencer: latches an instruction on the send button and walks the CPU through its phases.
//
//  state  | meaning
//  OFF    | powered down, waiting for power button
//  FETCH  | waiting for send button, latches instruction
//  DECODE | waiting for ALU decode done
//  READ   | fixed RAM operand-read latency
//  CALC   | waiting for ALU calc done
//  STORE  | RAM write (and clear-all for CLEAR) until stored
//  SHOW   | display update until shown
module module_control
  import module_control_pkg::*;
#(
  parameter int READ_CYCLES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                btnLigar,
  input  logic                btnEnviar,
  input  logic [INSTR_W-1:0]  instrucao,
  input  logic                decoded,
  input  logic                calculated,
  input  logic                stored,
  input  logic                shown,
  output logic [2:0]          stateCPU,
  output logic [2:0]          opcode,
  output logic [3:0]          endDest,
  output logic [3:0]          endSrc1,
  output logic [3:0]          endSrc2,
  output logic                sinalImm,
  output logic [5:0]          Imm,
  output logic                writeEnable,
  output logic                clearAll,
  output logic                displayEnable,
  output logic                erro
);

  localparam logic [7:0] READ_LOAD = 8'(READ_CYCLES - 1);
  localparam logic [7:0] WDOG_LOAD = 8'(TIMEOUT);

  state_t             state, next_state;
  logic [INSTR_W-1:0] ir;
  logic [7:0]         cnt;
  logic               lig_edge, env_edge;
  logic               ir_load, set_erro, clr_erro, expired;

  module_edge_detect u_lig (.clk(clk), .rst_n(rst_n), .btn(btnLigar),  .pulse(lig_edge));
  module_edge_detect u_env (.clk(clk), .rst_n(rst_n), .btn(btnEnviar), .pulse(env_edge));

  // cnt is a down-counter loaded on every state change; zero is the terminal count
  assign expired = (cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_OFF;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    ir_load    = 1'b0;
    set_erro   = 1'b0;
    clr_erro   = 1'b0;
    if (state != ST_OFF && lig_edge) begin
      next_state = ST_OFF;
    end else begin
      case (state)
        ST_OFF: if (lig_edge) begin
          next_state = ST_FETCH;
          clr_erro   = 1'b1;
        end
        ST_FETCH: if (env_edge) begin
          next_state = ST_DECODE;
          ir_load    = 1'b1;
        end
        ST_DECODE: begin
          if (decoded)      next_state = ST_READ;
          else if (expired) begin next_state = ST_FETCH; set_erro = 1'b1; end
        end
        ST_READ: if (expired) next_state = ST_CALC;
        ST_CALC: begin
          if (calculated)   next_state = (ir[OP_MSB:OP_LSB] == OP_DISPLAY) ? ST_SHOW : ST_STORE;
          else if (expired) begin next_state = ST_FETCH; set_erro = 1'b1; end
        end
        ST_STORE: begin
          if (stored)       next_state = ST_SHOW;
          else if (expired) begin next_state = ST_FETCH; set_erro = 1'b1; end
        end
        ST_SHOW: begin
          if (shown)        next_state = ST_FETCH;
          else if (expired) begin next_state = ST_FETCH; set_erro = 1'b1; end
        end
        default: next_state = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir            <= '0;
      cnt           <= 8'd0;
      erro          <= 1'b0;
      writeEnable   <= 1'b0;
      clearAll      <= 1'b0;
      displayEnable <= 1'b0;
    end else begin
      if (ir_load) ir <= instrucao;
      if (next_state != state)
        cnt <= (next_state == ST_READ) ? READ_LOAD : WDOG_LOAD;
      else if (!expired)
        cnt <= cnt - 8'd1;
      if (clr_erro)      erro <= 1'b0;
      else if (set_erro) erro <= 1'b1;
      writeEnable   <= (next_state == ST_STORE);
      clearAll      <= (next_state == ST_STORE) && (ir[OP_MSB:OP_LSB] == OP_CLEAR);
      displayEnable <= (next_state == ST_SHOW);
    end
  end

  assign stateCPU = state;
  assign opcode   = ir[OP_MSB:OP_LSB];
  assign endDest  = ir[DEST_MSB:DEST_LSB];
  assign endSrc1  = ir[SRC1_MSB:SRC1_LSB];
  assign endSrc2  = ir[SRC2_MSB:SRC2_LSB];
  assign sinalImm = ir[SIGN_BIT];
  assign Imm      = ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_module_control.sv
// Directed bench for the Mini-CPU sequencer: per-cycle vector table plus timeout/abort/reset sequences.
module tb_module_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btnLigar = 1'b0, btnEnviar = 1'b0;
  logic [17:0] instrucao = '0;
  logic        decoded = 1'b0, calculated = 1'b0, stored = 1'b0, shown = 1'b0;
  logic [2:0]  stateCPU, opcode;
  logic [3:0]  endDest, endSrc1, endSrc2;
  logic        sinalImm;
  logic [5:0]  Imm;
  logic        writeEnable, clearAll, displayEnable, erro;

  int tests = 0;
  int fails = 0;

  localparam logic [17:0] I1 = 18'b001_0011_0001_0010_000;
  localparam logic [17:0] I2 = 18'b110_0000_0000_0000_000;
  localparam logic [17:0] I3 = 18'b111_0000_0000_0000_000;

  module_control #(.READ_CYCLES(2), .TIMEOUT(255)) dut (
    .clk(clk), .rst_n(rst_n), .btnLigar(btnLigar), .btnEnviar(btnEnviar),
    .instrucao(instrucao), .decoded(decoded), .calculated(calculated),
    .stored(stored), .shown(shown), .stateCPU(stateCPU), .opcode(opcode),
    .endDest(endDest), .endSrc1(endSrc1), .endSrc2(endSrc2), .sinalImm(sinalImm),
    .Imm(Imm), .writeEnable(writeEnable), .clearAll(clearAll),
    .displayEnable(displayEnable), .erro(erro)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        lig, env;
    logic [17:0] ins;
    logic        dec, cal, sto, shw;
    logic [2:0]  st;
    logic        we, clr, de, er;
    logic [2:0]  op;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(logic l, logic e, logic [17:0] ins, logic d, logic c, logic s, logic h,
                              logic [2:0] st, logic we, logic clr, logic de, logic er, logic [2:0] op);
    vec_t v;
    v.lig = l; v.env = e; v.ins = ins; v.dec = d; v.cal = c; v.sto = s; v.shw = h;
    v.st = st; v.we = we; v.clr = clr; v.de = de; v.er = er; v.op = op;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic l, input logic e, input logic d, input logic c,
                       input logic s, input logic h);
    btnLigar = l; btnEnviar = e; decoded = d; calculated = c; stored = s; shown = h;
    @(posedge clk); #1;
  endtask

  // from FETCH with buttons released: send, one-cycle decode ack, two READ cycles, into CALC
  task automatic go_calc(input logic [17:0] ins);
    instrucao = ins;
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("go_calc_state", stateCPU, 3'b100);
  endtask

  task automatic calc_timeout();
    go_calc(I1);
    repeat (255) drive(0, 0, 0, 0, 0, 0);
    chk("wdog_last_wait_state", stateCPU, 3'b100);
    chk("wdog_last_wait_erro", erro, 1'b0);
    drive(0, 0, 0, 0, 0, 0);
    chk("wdog_abort_state", stateCPU, 3'b001);
    chk("wdog_abort_erro", erro, 1'b1);
  endtask

  initial begin
    tbl[0]  = mk(0,1,I1,0,0,0,0, 3'd0,0,0,0,0, 3'd0);
    tbl[1]  = mk(1,1,I1,0,0,0,0, 3'd1,0,0,0,0, 3'd0);
    tbl[2]  = mk(1,1,I1,0,0,0,0, 3'd1,0,0,0,0, 3'd0);
    tbl[3]  = mk(0,0,I1,0,0,0,0, 3'd1,0,0,0,0, 3'd0);
    tbl[4]  = mk(0,1,I1,0,0,0,0, 3'd2,0,0,0,0, 3'd1);
    tbl[5]  = mk(0,0,I1,0,0,0,0, 3'd2,0,0,0,0, 3'd1);
    tbl[6]  = mk(0,0,I1,1,0,0,0, 3'd3,0,0,0,0, 3'd1);
    tbl[7]  = mk(0,0,I1,0,0,0,0, 3'd3,0,0,0,0, 3'd1);
    tbl[8]  = mk(0,0,I1,0,0,0,0, 3'd4,0,0,0,0, 3'd1);
    tbl[9]  = mk(0,0,I1,0,0,0,0, 3'd4,0,0,0,0, 3'd1);
    tbl[10] = mk(0,0,I1,0,1,0,0, 3'd6,1,0,0,0, 3'd1);
    tbl[11] = mk(0,0,I1,0,0,0,0, 3'd6,1,0,0,0, 3'd1);
    tbl[12] = mk(0,0,I1,0,0,1,0, 3'd5,0,0,1,0, 3'd1);
    tbl[13] = mk(0,0,I1,0,0,0,0, 3'd5,0,0,1,0, 3'd1);
    tbl[14] = mk(0,0,I1,0,0,0,1, 3'd1,0,0,0,0, 3'd1);
    tbl[15] = mk(0,1,I2,0,0,0,0, 3'd2,0,0,0,0, 3'd6);
    tbl[16] = mk(0,0,I2,1,0,0,0, 3'd3,0,0,0,0, 3'd6);
    tbl[17] = mk(0,0,I2,0,1,0,0, 3'd3,0,0,0,0, 3'd6);
    tbl[18] = mk(0,0,I2,0,0,0,0, 3'd4,0,0,0,0, 3'd6);
    tbl[19] = mk(0,0,I2,0,1,0,0, 3'd6,1,1,0,0, 3'd6);
    tbl[20] = mk(0,0,I2,0,0,1,0, 3'd5,0,0,1,0, 3'd6);
    tbl[21] = mk(0,0,I2,0,0,0,1, 3'd1,0,0,0,0, 3'd6);
    tbl[22] = mk(0,1,I3,0,0,0,0, 3'd2,0,0,0,0, 3'd7);
    tbl[23] = mk(0,0,I3,1,0,0,0, 3'd3,0,0,0,0, 3'd7);
    tbl[24] = mk(0,0,I3,0,0,0,0, 3'd3,0,0,0,0, 3'd7);
    tbl[25] = mk(0,0,I3,0,0,0,0, 3'd4,0,0,0,0, 3'd7);
    tbl[26] = mk(0,0,I3,0,1,0,0, 3'd5,0,0,1,0, 3'd7);
    tbl[27] = mk(0,0,I3,0,0,0,1, 3'd1,0,0,0,0, 3'd7);
    tbl[28] = mk(0,0,I3,1,1,1,1, 3'd1,0,0,0,0, 3'd7);

    // reset with the send button held
    rst_n = 1'b0; btnEnviar = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", stateCPU, 3'd0);
    chk("rst_strobes", {writeEnable, clearAll, displayEnable}, 3'b000);
    chk("rst_erro", erro, 1'b0);
    chk("rst_ir", {opcode, endDest, endSrc1, endSrc2, Imm}, 21'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      instrucao = tbl[i].ins;
      drive(tbl[i].lig, tbl[i].env, tbl[i].dec, tbl[i].cal, tbl[i].sto, tbl[i].shw);
      chk($sformatf("v%0d_state", i), stateCPU, tbl[i].st);
      chk($sformatf("v%0d_we", i), writeEnable, tbl[i].we);
      chk($sformatf("v%0d_clr", i), clearAll, tbl[i].clr);
      chk($sformatf("v%0d_de", i), displayEnable, tbl[i].de);
      chk($sformatf("v%0d_erro", i), erro, tbl[i].er);
      chk($sformatf("v%0d_op", i), opcode, tbl[i].op);
      if (i == 4) begin
        chk("fld_dest", endDest, 4'd3);
        chk("fld_src1", endSrc1, 4'd1);
        chk("fld_src2", endSrc2, 4'd2);
        chk("fld_sign", sinalImm, 1'b0);
        chk("fld_imm",  Imm, 6'd16);
      end
    end

    // watchdog abort in CALC
    calc_timeout();

    // handshake on the terminal-count cycle wins; instruction completes with erro kept
    go_calc(I1);
    repeat (255) drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    chk("tie_state", stateCPU, 3'd6);
    chk("tie_erro", erro, 1'b1);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 1);
    chk("tie_done_state", stateCPU, 3'd1);
    chk("tie_done_erro", erro, 1'b1);

    // power button in READ together with a send press
    instrucao = I1;
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0);
    chk("abort_pre_state", stateCPU, 3'd3);
    instrucao = I3;
    drive(1, 1, 0, 0, 0, 0);
    chk("abort_state", stateCPU, 3'd0);
    chk("abort_strobes", {writeEnable, clearAll, displayEnable}, 3'b000);
    chk("abort_ir", {opcode, endDest, endSrc1, endSrc2}, {3'b001, 4'd3, 4'd1, 4'd2});
    chk("abort_erro_kept", erro, 1'b1);
    drive(1, 0, 0, 0, 0, 0);
    chk("off_hold_state", stateCPU, 3'd0);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    chk("poweron_state", stateCPU, 3'd1);
    chk("poweron_erro_clr", erro, 1'b0);
    drive(0, 0, 0, 0, 0, 0);

    // set erro again, then reset in the middle of a CLEAR store
    calc_timeout();
    go_calc(I2);
    drive(0, 0, 0, 1, 0, 0);
    chk("mid_store_we", writeEnable, 1'b1);
    chk("mid_store_clr", clearAll, 1'b1);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    chk("rst_store_state", stateCPU, 3'd0);
    chk("rst_store_strobes", {writeEnable, clearAll, displayEnable}, 3'b000);
    chk("rst_store_erro", erro, 1'b0);
    chk("rst_store_ir", opcode, 3'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
